fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
- Holds the PC, drives the instruction-memory address, and selects the next PC (PC+4 or the redirect target from EX).
- Registers the fetched instruction, its PC and its PC+4 into the decode stage.
- Consumes fstall, dstall and dflush from the hazard unit; the same unit's PCSrc arrives here as pc_src.

Parameters:
- XLEN, 32, data/address width.
- PC_RESET, 32'h0000_3000, PC value after reset (text-segment base).
- NOP, 32'h0000_0013, instruction injected on flush/reset (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_src  in  1  redirect request from EX (taken branch/jump).
- pc_target  in  XLEN  redirect target from EX.
- fstall  in  1  hold PC.
- dstall  in  1  hold IF/ID register.
- dflush  in  1  squash IF/ID contents.
- imem_addr  out  XLEN  current PC to instruction memory (combinational read).
- imem_rdata  in  XLEN  instruction at imem_addr, same cycle.
- f_pc  out  XLEN  current PC (debug/trace).
- d_pc  out  XLEN  PC of instruction in ID.
- d_pc4  out  XLEN  d_pc+4.
- d_ir  out  XLEN  instruction in ID.
- d_valid  out  1  ID holds a real (non-bubble) instruction.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): pc=PC_RESET; d_pc=0; d_pc4=0; d_ir=NOP; d_valid=0. Takes effect immediately, not at the next edge.
- imem_addr = f_pc = pc, combinational from the register.
- PC update at the rising edge, by priority:
  1. pc_src=1: pc <= {pc_target[XLEN-1:2],2'b00}. Low two bits are forced to 0, misaligned targets are not trapped. Overrides fstall.
  2. fstall=1: pc holds.
  3. Otherwise pc <= pc+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000).
- IF/ID update at the rising edge, by priority:
  1. dflush=1: d_ir<=NOP, d_valid<=0, d_pc<=0, d_pc4<=0. Overrides dstall.
  2. dstall=1: all d_* hold.
  3. Otherwise d_ir<=imem_rdata, d_pc<=pc, d_pc4<=pc+4, d_valid<=1.
- Latency: an instruction at PC p appears on d_ir one edge after pc==p, provided no stall or flush.
- Redirect: the pc_src and dflush edge discards the wrong-path fetch. The target instruction reaches ID two edges after pc_src was sampled.
- Load-use (fstall=dstall=1, dflush=0): PC and IF/ID both freeze for exactly the asserted cycles. No instruction is lost or duplicated.
- fstall=1 with dstall=0 (not produced by the hazard unit but legal): the same PC is refetched, so ID sees that instruction again. This is permitted.
- pc_src=1 with dflush=0 (illegal pairing): PC redirects, ID loads the wrong-path instruction. No checking is done.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetch[31:0], perf_stall[31:0] and perf_flush[31:0], all reset to 0 and wrapping at 2^32.
  - perf_fetch increments on each edge where IF/ID loads a valid instruction.
  - perf_stall increments on each edge with dstall=1 and dflush=0.
  - perf_flush increments on each edge with dflush=1.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package: XLEN, PC_RESET, NOP_INSTR, and the PC increment constant 4.
- One natural sub-module, if_id_reg: a generic pipeline register with flush/stall priority, bubble value and valid bit. It is reused for ID/EX and later stages.
- PC register and next-PC mux stay inline.

Test Plan:
- Reset then free-run with imem returning addr^32'hA5A5_0000 -> f_pc sequence 0x3000, 0x3004, 0x3008. d_ir at the second edge equals 0xA5A5_3000. d_valid goes 0 then 1.
- fstall=dstall=1 for 2 cycles starting at pc=0x3008 -> pc stays 0x3008 and d_pc stays 0x3004 for 2 edges, then resumes 0x300C. perf_stall=2 when FETCH_PERF_CNT_EN is defined.
- pc_src=1, pc_target=0x3103, dflush=1, fstall=1 at pc=0x3010 -> next pc=0x3100, d_ir=NOP, d_valid=0. The following edge gives d_pc=0x3100.
- dflush=1 and dstall=1 together -> IF/ID becomes a bubble (NOP, d_valid=0), not held.
- pc forced near wrap: pc_target=0xFFFF_FFFC then free-run -> next pc=0x0000_0000, d_pc4 of that instruction=0x0000_0000.
- rst asserted asynchronously mid-stall at pc=0x3040 -> pc=0x3000 and d_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I fetch stage and its IF/ID register.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET      = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] ir;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc4: '0, ir: NOP_INSTR};

  // Redirect targets are word-aligned silently; misalignment is never trapped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, instruction-memory port and IF/ID outputs.
// Performance counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            fstall;
  logic            dstall;
  logic            dflush;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc4;
  logic [XLEN-1:0] d_ir;
  logic            d_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetch;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_flush;
`endif

  modport master (
    input  pc_src, pc_target, fstall, dstall, dflush, imem_rdata,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetch, perf_stall, perf_flush,
`endif
    output imem_addr, f_pc, d_pc, d_pc4, d_ir, d_valid
  );

  modport slave (
    output pc_src, pc_target, fstall, dstall, dflush, imem_rdata,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetch, perf_stall, perf_flush,
`endif
    input  imem_addr, f_pc, d_pc, d_pc4, d_ir, d_valid
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with flush-over-stall priority, bubble value and valid bit.
module fetch_stage_if_id_reg #(
  parameter int           W      = 32,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         valid_nxt,
  input  logic [W-1:0] data_nxt,
  output logic [W-1:0] data,
  output logic         valid
);

  // Flush wins over stall so a squashed slot can never be held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= BUBBLE;
      valid <= 1'b0;
    end else if (flush) begin
      data  <= BUBBLE;
      valid <= 1'b0;
    end else if (!stall) begin
      data  <= data_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC register, next-PC select and IF/ID register.
// Optional counters perf_fetch/perf_stall/perf_flush are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  if_id_t          if_id_next;
  if_id_t          if_id;
  logic            id_valid;

  assign pc_plus4 = pc + PC_INC;

  // A redirect from EX outranks a fetch stall.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.pc_src) begin
      pc_next = align_pc(bus.pc_target);
    end else if (bus.fstall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.f_pc      = pc;
  assign if_id_next    = '{pc: pc, pc4: pc_plus4, ir: bus.imem_rdata};

  fetch_stage_if_id_reg #(
    .W      ($bits(if_id_t)),
    .BUBBLE (IF_ID_BUBBLE)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.dflush),
    .stall     (bus.dstall),
    .valid_nxt (1'b1),
    .data_nxt  (if_id_next),
    .data      (if_id),
    .valid     (id_valid)
  );

  assign bus.d_pc    = if_id.pc;
  assign bus.d_pc4   = if_id.pc4;
  assign bus.d_ir    = if_id.ir;
  assign bus.d_valid = id_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!bus.dflush && !bus.dstall) fetch_cnt <= fetch_cnt + 32'd1;
      if (!bus.dflush && bus.dstall)  stall_cnt <= stall_cnt + 32'd1;
      if (bus.dflush)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_fetch = fetch_cnt;
  assign bus.perf_stall = stall_cnt;
  assign bus.perf_flush = flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard testbench for fetch_stage: directed hazard scenarios, then randomized traffic.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;
    logic [31:0] d_ir;
    logic        d_valid;
    logic [31:0] pf;
    logic [31:0] ps;
    logic [31:0] pfl;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [31:0] m_pc, m_dpc, m_dpc4, m_dir;
  logic        m_dvalid;
  logic [31:0] m_pf, m_ps, m_pfl;

  function automatic logic [31:0] imem_model(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0000_3000;
    m_dpc    = 32'h0;
    m_dpc4   = 32'h0;
    m_dir    = 32'h0000_0013;
    m_dvalid = 1'b0;
    m_pf     = 32'h0;
    m_ps     = 32'h0;
    m_pfl    = 32'h0;
  endtask

  // One clock edge of the fetch stage as described by its behavioural rules.
  task automatic model_edge(input logic src, input logic [31:0] tgt,
                            input logic fs, input logic ds, input logic df);
    logic [31:0] cur_pc;
    cur_pc = m_pc;
    if (df) begin
      m_dir = 32'h0000_0013; m_dvalid = 1'b0; m_dpc = 32'h0; m_dpc4 = 32'h0;
      m_pfl = m_pfl + 1;
    end else if (ds) begin
      m_ps = m_ps + 1;
    end else begin
      m_dir = imem_model(cur_pc); m_dpc = cur_pc; m_dpc4 = cur_pc + 4; m_dvalid = 1'b1;
      m_pf = m_pf + 1;
    end
    if (src)      m_pc = (tgt / 4) * 4;
    else if (!fs) m_pc = cur_pc + 4;
  endtask

  task automatic push_expect();
    exp_t e;
    e.pc = m_pc; e.d_pc = m_dpc; e.d_pc4 = m_dpc4; e.d_ir = m_dir; e.d_valid = m_dvalid;
    e.pf = m_pf; e.ps = m_ps; e.pfl = m_pfl;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic src, input logic [31:0] tgt,
                                input logic fs, input logic ds, input logic df);
    bus.pc_src    = src;
    bus.pc_target = tgt;
    bus.fstall    = fs;
    bus.dstall    = ds;
    bus.dflush    = df;
    model_edge(src, tgt, fs, ds, df);
    push_expect();
    @(posedge clk);
    #1 -> sample_ev;
    @(negedge clk);
  endtask

  task automatic async_reset_now();
    rst = 1'b1;
    model_reset();
    push_expect();
    #1 -> sample_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        e = exp_q.pop_front();
        check_output("f_pc", bus.f_pc, e.pc);
        check_output("imem_addr", bus.imem_addr, e.pc);
        check_output("d_pc", bus.d_pc, e.d_pc);
        check_output("d_pc4", bus.d_pc4, e.d_pc4);
        check_output("d_ir", bus.d_ir, e.d_ir);
        check_output("d_valid", {31'b0, bus.d_valid}, {31'b0, e.d_valid});
`ifdef FETCH_PERF_CNT_EN
        check_output("perf_fetch", bus.perf_fetch, e.pf);
        check_output("perf_stall", bus.perf_stall, e.ps);
        check_output("perf_flush", bus.perf_flush, e.pfl);
`endif
      end
    end
  end

  initial begin : driver
    int sel;
    bus.pc_src    = 1'b0;
    bus.pc_target = 32'h0;
    bus.fstall    = 1'b0;
    bus.dstall    = 1'b0;
    bus.dflush    = 1'b0;

    #1 async_reset_now();
    @(negedge clk);
    rst = 1'b0;

    // Free run from reset, then a two-cycle load-use stall at 0x3008.
    repeat (2) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (2) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Misaligned redirect with flush and fetch stall at 0x3010.
    apply_stimulus(1'b1, 32'h0000_3103, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush together with decode stall must bubble, not hold.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // PC wrap at the top of the address space.
    apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomized mix of hazard-unit patterns plus the legal oddities.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 1, 2, 3, 4: apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        5, 6:          apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        7:             apply_stimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        8:             apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        9:             apply_stimulus(1'b0, $urandom, 1'b0, 1'b1, 1'b1);
        10:            apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        default:       apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      endcase
    end

    // Asynchronous reset in the middle of a stall at 0x3040.
    apply_stimulus(1'b1, 32'h0000_3040, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 async_reset_now();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    #10;
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
